// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus decode for the 2 KB work RAM and the PRG ROM, with
// read data returned one clock after the address.
// Build option OAM_DMA_EN: enables the $4014 OAM DMA engine. When it is undefined,
// rdy stays high, the OAM port is idle and $4014 is an ordinary unmapped address.
module cpu_bus_responder #(
  parameter int RAM_AW = 11,
  parameter int PRG_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              rdy,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_data,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              oam_we
);

  // Source of the read completing in the current cycle.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_PRG  = 2'd2;

  logic [15:0] ea;      // effective address: CPU bus, or DMA source while stalled
  logic        rd_en;   // a read is issued this cycle
  logic        wr_en;   // a CPU write is accepted this cycle
  logic        in_ram;
  logic        in_prg;
  logic [1:0]  src;
  logic [7:0]  ram_q;
  logic [7:0]  hold_q;  // last delivered value, doubles as the open-bus value
  logic [7:0]  ram [2**RAM_AW];

  assign in_ram   = (ea[15:13] == 3'b000);
  assign in_prg   = ea[15];
  assign prg_addr = rst ? '0 : ea[PRG_AW-1:0];

`ifdef OAM_DMA_EN
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_ALIGN2 = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0] state;
  logic [7:0] page;
  logic [7:0] idx;
  logic       parity;
  logic       idle;
  logic       trig;

  assign idle      = (state == S_IDLE);
  assign ea        = idle ? cpu_addr : {page, idx};
  assign rd_en     = idle ? cpu_rw : (state == S_READ);
  assign wr_en     = idle & ~cpu_rw;
  assign trig      = wr_en && (cpu_addr == 16'h4014);
  assign rdy       = idle;
  // WRITE always follows READ, so cpu_din already carries the fetched byte.
  assign oam_we    = (state == S_WRITE);
  assign oam_addr  = oam_we ? idx : 8'h00;
  assign oam_wdata = oam_we ? cpu_din : 8'h00;

  // DMA sequencer: optional alignment cycle, then 256 read/write pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        S_IDLE:   if (trig) begin
                    page  <= cpu_dout;
                    idx   <= 8'h00;
                    state <= S_ALIGN;
                  end
        S_ALIGN:  state <= parity ? S_ALIGN2 : S_READ;
        S_ALIGN2: state <= S_READ;
        S_READ:   state <= S_WRITE;
        S_WRITE:  begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? S_IDLE : S_READ;
                  end
        default:  state <= S_IDLE;
      endcase
    end
  end
`else
  assign ea        = cpu_addr;
  assign rd_en     = cpu_rw;
  assign wr_en     = ~cpu_rw;
  assign rdy       = 1'b1;
  assign oam_we    = 1'b0;
  assign oam_addr  = 8'h00;
  assign oam_wdata = 8'h00;
`endif

  // Work RAM: synchronous write from the CPU, synchronous read for both masters.
  always_ff @(posedge clk) begin
    if (wr_en && in_ram) ram[ea[RAM_AW-1:0]] <= cpu_dout;
    ram_q <= ram[ea[RAM_AW-1:0]];
  end

  // Track which source answers next cycle and keep the last value for open bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src    <= SRC_NONE;
      hold_q <= 8'h00;
    end else begin
      hold_q <= cpu_din;
      if (rd_en && in_ram)      src <= SRC_RAM;
      else if (rd_en && in_prg) src <= SRC_PRG;
      else                      src <= SRC_NONE;
    end
  end

  // ROM data arrives straight from the ROM one clock after prg_addr.
  always_comb begin
    cpu_din = hold_q;
    case (src)
      SRC_RAM: cpu_din = ram_q;
      SRC_PRG: cpu_din = prg_data;
      default: cpu_din = hold_q;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed bench for cpu_bus_responder with a bus-level
// reference model checked every cycle, plus literal expectations from the test plan.
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h4000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        rdy;
  logic [14:0] prg_addr;
  logic [7:0]  prg_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  cpu_bus_responder #(.RAM_AW(11), .PRG_AW(15)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .rdy(rdy), .prg_addr(prg_addr), .prg_data(prg_data),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  always #5 clk = ~clk;

  // Synchronous PRG ROM, one clock of latency.
  logic [7:0] prg_mem [32768];
  always @(posedge clk) prg_data <= prg_mem[prg_addr];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bus-transaction level) ----------------
  logic [7:0] m_ram [2048];
  logic [7:0] m_din = 8'h00;
  logic [7:0] m_page = 8'h00;
  int mk = -1;     // index of the current cycle within a DMA stall, -1 when free
  int mlen = 513;  // stall length of the current DMA
  int mpar = 0;    // clock edges since reset release

  task automatic model_read(input logic [15:0] a);
    if (a < 16'h2000) m_din = m_ram[a[10:0]];
    else if (a[15])   m_din = prg_mem[a[14:0]];
  endtask

  // Stall cycle layout: alignment (1 or 2 cycles), then READ at even and
  // WRITE at odd offsets; the last WRITE is the final stalled cycle.
  function automatic bit m_we();
    return (mk >= 0) && (mk >= mlen - 512) && (((mk - (mlen - 512)) % 2) == 1);
  endfunction
  function automatic int m_idx();
    return (mk - (mlen - 512)) / 2;
  endfunction

  task automatic model_step();
    if (rst) begin
      mk = -1; m_din = 8'h00; mpar = 0;
      return;
    end
    if (mk < 0) begin
      if (cpu_rw) model_read(cpu_addr);
      else begin
        if (cpu_addr < 16'h2000) m_ram[cpu_addr[10:0]] = cpu_dout;
`ifdef OAM_DMA_EN
        if (cpu_addr == 16'h4014) begin
          m_page = cpu_dout;
          mk = 0;
          mlen = ((mpar % 2) == 1) ? 513 : 514;  // parity in the next cycle decides
        end
`endif
      end
    end else begin
      if (mk >= mlen - 512 && ((mk - (mlen - 512)) % 2) == 0)
        model_read({m_page, 8'(m_idx())});
      mk++;
      if (mk == mlen) mk = -1;
    end
    mpar++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("rdy", {31'd0, rdy}, {31'd0, mk < 0});
      chk("cpu_din", {24'd0, cpu_din}, {24'd0, m_din});
      chk("oam_we", {31'd0, oam_we}, {31'd0, m_we()});
      if (m_we()) begin
        chk("oam_addr", {24'd0, oam_addr}, m_idx());
        chk("oam_wdata", {24'd0, oam_wdata}, {24'd0, m_din});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    #1;
    cpu_addr = a; cpu_rw = rw; cpu_dout = d;
  endtask

`ifdef OAM_DMA_EN
  // Trigger a DMA of page 2 in a cycle whose parity equals want_par, then
  // drive sa/sd writes during the stall. abort_at>0 resets after that many bytes.
  task automatic run_dma(input int want_par, input logic [15:0] sa, input logic [7:0] sd,
                         input int abort_at, output int len, output int pulses,
                         output int bad, output int first_addr);
    int tries = 0;
    len = 0; pulses = 0; bad = 0; first_addr = -1;
    do begin
      @(negedge clk); #1;
      cpu_addr = 16'h4000; cpu_rw = 1'b1;
      tries++;
    end while ((mpar % 2) != want_par && tries < 4);
    if ((mpar % 2) != want_par) chk("parity_align_timeout", 0, 1);
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h02;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rdy) break;
      len++;
      if (oam_we) begin
        if (first_addr < 0) first_addr = oam_addr;
        if (oam_addr != 8'(pulses) || oam_wdata != (oam_addr ^ 8'hFF)) bad++;
        pulses++;
      end
      if (c == 0) begin
        #1; cpu_addr = sa; cpu_rw = 1'b0; cpu_dout = sd;
      end
      if (abort_at > 0 && pulses == abort_at) begin
        #1; rst = 1'b1;
        #1;
        chk("abort_rdy", {31'd0, rdy}, 1);
        chk("abort_oam_we", {31'd0, oam_we}, 0);
        cpu_addr = 16'h4000; cpu_rw = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
        return;
      end
    end
    #1; cpu_addr = 16'h4000; cpu_rw = 1'b1;
  endtask
`endif

  initial begin
`ifdef OAM_DMA_EN
    int len, pulses, bad, first;
`endif
    for (int i = 0; i < 32768; i++) prg_mem[i] = 8'(i * 7 + 3);
    prg_mem[15'h7FFC] = 8'h00;
    prg_mem[15'h7FFD] = 8'h80;
    prg_mem[15'h1000] = 8'h12;

    repeat (3) @(negedge clk);
    chk("rst_cpu_din", {24'd0, cpu_din}, 0);
    chk("rst_rdy", {31'd0, rdy}, 1);
    chk("rst_prg_addr", {17'd0, prg_addr}, 0);
    chk("rst_oam_we", {31'd0, oam_we}, 0);
    chk("rst_oam_addr", {24'd0, oam_addr}, 0);
    chk("rst_oam_wdata", {24'd0, oam_wdata}, 0);
    #1; rst = 1'b0; chk_en = 1'b1;

    // RAM and its mirrors
    bus(16'h0002, 1'b0, 8'hA5);
    bus(16'h0003, 1'b0, 8'h5A);
    bus(16'h0803, 1'b1, 8'h00); @(negedge clk); chk("ram_0803", {24'd0, cpu_din}, 8'h5A);
    bus(16'h0802, 1'b1, 8'h00); @(negedge clk); chk("ram_0802", {24'd0, cpu_din}, 8'hA5);
    bus(16'h1803, 1'b1, 8'h00); @(negedge clk); chk("ram_1803", {24'd0, cpu_din}, 8'h5A);
    bus(16'h1802, 1'b1, 8'h00); @(negedge clk); chk("ram_1802", {24'd0, cpu_din}, 8'hA5);

    // Reset vector fetch from PRG
    bus(16'hFFFC, 1'b1, 8'h00); #1; chk("prg_addr_fffc", {17'd0, prg_addr}, 15'h7FFC);
    @(negedge clk); chk("prg_fffc", {24'd0, cpu_din}, 8'h00);
    bus(16'hFFFD, 1'b1, 8'h00); #1; chk("prg_addr_fffd", {17'd0, prg_addr}, 15'h7FFD);
    @(negedge clk); chk("prg_fffd", {24'd0, cpu_din}, 8'h80);

    // Open bus and ignored ROM write
    bus(16'h0000, 1'b0, 8'h3C);
    bus(16'h0000, 1'b1, 8'h00); @(negedge clk); chk("ram_0000", {24'd0, cpu_din}, 8'h3C);
    bus(16'h5000, 1'b1, 8'h00); @(negedge clk); chk("open_bus_5000", {24'd0, cpu_din}, 8'h3C);
    @(negedge clk); chk("open_bus_hold", {24'd0, cpu_din}, 8'h3C);
    bus(16'h9000, 1'b0, 8'h55);
    bus(16'h9000, 1'b1, 8'h00); @(negedge clk); chk("prg_9000_unchanged", {24'd0, cpu_din}, 8'h12);

`ifdef OAM_DMA_EN
    for (int i = 0; i < 256; i++) bus(16'h0200 + 16'(i), 1'b0, 8'(i) ^ 8'hFF);

    // ALIGN sees parity 0; further $4014 writes during the stall are ignored
    run_dma(1, 16'h4014, 8'h03, 0, len, pulses, bad, first);
    chk("dma_even_len", len, 513);
    chk("dma_even_pulses", pulses, 256);
    chk("dma_even_bad", bad, 0);
    chk("dma_even_first", first, 0);

    // ALIGN sees parity 1; CPU writes to $0000 during the stall are dropped
    run_dma(0, 16'h0000, 8'h77, 0, len, pulses, bad, first);
    chk("dma_odd_len", len, 514);
    chk("dma_odd_pulses", pulses, 256);
    chk("dma_odd_bad", bad, 0);
    bus(16'h0000, 1'b1, 8'h00); @(negedge clk); chk("ram_0000_kept", {24'd0, cpu_din}, 8'h3C);

    // Reset part way through, then a fresh DMA starts from index 0
    run_dma(1, 16'h0000, 8'h77, 100, len, pulses, bad, first);
    chk("abort_pulses", pulses, 100);
    run_dma(0, 16'h4000, 8'h00, 0, len, pulses, bad, first);
    chk("fresh_len", len, 514);
    chk("fresh_pulses", pulses, 256);
    chk("fresh_first", first, 0);
    chk("fresh_bad", bad, 0);
`else
    // Without the DMA engine $4014 is plain unmapped space
    bus(16'h4014, 1'b0, 8'h02);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nodma_rdy", {31'd0, rdy}, 1);
      chk("nodma_oam_we", {31'd0, oam_we}, 0);
    end
    bus(16'h4014, 1'b1, 8'h00); @(negedge clk); chk("nodma_open_bus", {24'd0, cpu_din}, 8'h12);
`endif

    bus(16'h4000, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
Memory-side responder for the CPU address/data bus. It decodes each CPU bus cycle and returns read data one clock later. It services writes to the 2 KB internal work RAM and fronts the 32 KB PRG ROM. A write to $4014 starts an OAM DMA engine that stalls the CPU via rdy and copies one 256-byte page into sprite OAM.

Parameters:
RAM_AW, 11, work RAM address width (2^RAM_AW bytes, mirrored through $0000-$1FFF)
PRG_AW, 15, PRG ROM address width (mapped at $8000-$FFFF)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU address bus
cpu_rw  in  1  1 = read, 0 = write
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data returned to CPU
rdy  out  1  1 = CPU may proceed; 0 = CPU stalled (DMA active)
prg_addr  out  PRG_AW  PRG ROM address (synchronous ROM, 1-clock latency)
prg_data  in  8  PRG ROM data, valid the clock after prg_addr
oam_addr  out  8  OAM write address
oam_wdata  out  8  OAM write data
oam_we  out  1  OAM write strobe, one clock per byte

Behaviour:
- Reset values: cpu_din=0, rdy=1, prg_addr=0, oam_addr=0, oam_wdata=0, oam_we=0. DMA state=IDLE, index=0, parity=0. RAM contents are not reset.
- Decode, using the effective address (cpu_addr when IDLE, DMA source address otherwise):
  - $0000-$1FFF: RAM at addr[RAM_AW-1:0].
  - $8000-$FFFF: PRG at addr[PRG_AW-1:0].
  - $4014 write: DMA trigger.
  - All other addresses: unmapped.
- Read latency is 1 clock. Address presented in cycle t; cpu_din is valid from cycle t+1 and held until the next mapped read completes.
- Unmapped reads (open bus): cpu_din keeps its previous value.
- RAM write: when cpu_rw=0 and the address is in the RAM window, the RAM is written at the clock edge. Writes to PRG and other unmapped addresses are ignored.
- prg_addr is driven combinationally from the effective address every cycle.
- Parity bit toggles every clock after reset; it gives DMA alignment.
- DMA FSM states: IDLE, ALIGN, ALIGN2, READ, WRITE.
  - IDLE: on a $4014 write, latch page=cpu_dout, set index=0, go to ALIGN, rdy=0 from the next clock.
  - ALIGN: go to ALIGN2 if parity=1, else go to READ.
  - ALIGN2: go to READ.
  - READ: source address={page,index}; issue the read through the same decode as above.
  - WRITE: oam_we=1, oam_addr=index, oam_wdata=read result (open-bus value if the page is unmapped); index++; if index was 255, go to IDLE and set rdy=1, else go to READ.
  - Total stall is 513 clocks (parity=0 at ALIGN) or 514 clocks (parity=1).
- While rdy=0:
  - cpu_addr, cpu_rw and cpu_dout are ignored; no CPU RAM writes occur.
  - cpu_din is not updated by CPU-side decode. It holds its value except for DMA reads; the CPU re-reads after stall.
  - A further $4014 write does not restart DMA.
- Index wraps 255 -> 0 only at DMA termination; page is never incremented.
- Reset asserted mid-DMA: immediately return to IDLE, rdy=1, oam_we=0; partial OAM contents are left as written.
- A write to $4014 in the same cycle rdy returns to 1 is accepted normally and starts a new DMA.

Optional Feature:
OAM_DMA_EN.
- Defined: the DMA FSM and OAM ports behave as above.
- Undefined: no FSM; rdy is tied to 1; oam_we, oam_addr and oam_wdata are tied to 0; $4014 is treated as unmapped (write ignored, read returns open bus).

Test Plan:
- Write $A5 to $0002, read $0802, then read $1802 -> cpu_din=$A5 one clock after each read address.
- Preload PRG[$7FFC]=$00 and [$7FFD]=$80; read $FFFC, then $FFFD -> prg_addr=$7FFC then $7FFD; cpu_din=$00 then $80, each 1 clock later.
- Read $0000 (value $3C), then read $5000 -> cpu_din stays $3C (open bus); write to $9000, then read back -> PRG data unchanged.
- Fill RAM $0200-$02FF with i^$FF; write $02 to $4014 on an even parity cycle -> rdy low for 513 clocks; 256 oam_we pulses with oam_addr 0..255 and oam_wdata=i^$FF.
- Repeat on an odd parity cycle -> rdy low for 514 clocks. During the stall, drive CPU writes to $0000 -> RAM[$0000] unchanged.
- Assert rst after 100 DMA bytes -> rdy=1 and oam_we=0 immediately; a subsequent $4014 write starts a fresh DMA from index 0.
